// File: rtl/mcdt_pkg.sv
// Shared types and sizing for the three-channel data multiplexer (mcdt_top).
// Arbitration policy is selected in mcdt_top by MCDT_RR_ARB_EN.
package mcdt_pkg;

    localparam int CH_NUM     = 3;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 32;
    localparam int MARGIN_W   = 6;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    typedef logic [1:0]        ch_id_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic  valid;
        data_t data;
    } ch_req_t;

    typedef struct packed {
        logic   vld;
        ch_id_t id;
        data_t  data;
    } mcdt_rsp_t;

    // Next channel in rotation order, wrapping after the last channel.
    function automatic ch_id_t ch_inc(input ch_id_t c);
        return (c == ch_id_t'(CH_NUM - 1)) ? ch_id_t'(0) : ch_id_t'(c + ch_id_t'(1));
    endfunction

endpackage

// File: rtl/mcdt_slave_fifo.sv
// Per-channel FIFO: valid/ready write side, pop/head read side, free-slot margin.
// Ready and margin come from the registered count only, so a pop never frees a slot in the same cycle.
module mcdt_slave_fifo
    import mcdt_pkg::*;
(
    input  logic                clk_i,
    input  logic                rstn_i,
    input  ch_req_t             req_i,
    output logic                ready_o,
    output logic [MARGIN_W-1:0] margin_o,
    input  logic                pop_i,
    output logic                empty_o,
    output data_t               head_o
);

    data_t               mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [MARGIN_W-1:0] cnt_q, cnt_d;
    logic                push;
    logic                pop;

    assign ready_o  = (cnt_q < MARGIN_W'(FIFO_DEPTH));
    assign margin_o = MARGIN_W'(FIFO_DEPTH) - cnt_q;
    assign empty_o  = (cnt_q == '0);
    assign head_o   = mem_q[rd_ptr_q];

    assign push = req_i.valid && ready_o;
    assign pop  = pop_i && !empty_o;

    // Pointers are log2(depth) wide and wrap naturally since depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + MARGIN_W'(1);
            2'b01:   cnt_d = cnt_q - MARGIN_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= req_i.data;
    end

endmodule

// File: rtl/mcdt_top.sv
// Three-channel multiplexer: per-channel FIFOs drained one word per cycle onto a tagged stream.
// Define MCDT_RR_ARB_EN for round-robin arbitration; otherwise fixed priority ch0 > ch1 > ch2.
module mcdt_top
    import mcdt_pkg::*;
(
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [DATA_W-1:0]   ch0_data_i,
    input  logic                ch0_valid_i,
    output logic                ch0_ready_o,
    output logic [MARGIN_W-1:0] ch0_margin_o,
    input  logic [DATA_W-1:0]   ch1_data_i,
    input  logic                ch1_valid_i,
    output logic                ch1_ready_o,
    output logic [MARGIN_W-1:0] ch1_margin_o,
    input  logic [DATA_W-1:0]   ch2_data_i,
    input  logic                ch2_valid_i,
    output logic                ch2_ready_o,
    output logic [MARGIN_W-1:0] ch2_margin_o,
    output logic [DATA_W-1:0]   mcdt_data_o,
    output logic                mcdt_val_o,
    output logic [1:0]          mcdt_id_o
);

    ch_req_t [CH_NUM-1:0]                req;
    logic    [CH_NUM-1:0]                ready;
    logic    [CH_NUM-1:0][MARGIN_W-1:0]  margin;
    logic    [CH_NUM-1:0]                empty;
    logic    [CH_NUM-1:0]                pop;
    data_t   [CH_NUM-1:0]                head;

    logic      gnt_vld;
    ch_id_t    gnt_id;
    mcdt_rsp_t rsp_q, rsp_d;

    assign req[0] = {ch0_valid_i, ch0_data_i};
    assign req[1] = {ch1_valid_i, ch1_data_i};
    assign req[2] = {ch2_valid_i, ch2_data_i};

    assign ch0_ready_o  = ready[0];
    assign ch1_ready_o  = ready[1];
    assign ch2_ready_o  = ready[2];
    assign ch0_margin_o = margin[0];
    assign ch1_margin_o = margin[1];
    assign ch2_margin_o = margin[2];

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        mcdt_slave_fifo u_fifo (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .req_i    (req[i]),
            .ready_o  (ready[i]),
            .margin_o (margin[i]),
            .pop_i    (pop[i]),
            .empty_o  (empty[i]),
            .head_o   (head[i])
        );
    end

`ifdef MCDT_RR_ARB_EN
    ch_id_t rr_ptr_q, rr_ptr_d;
    ch_id_t cand;

    // Search starts at the pointer; after a grant the pointer moves just past the winner.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        cand    = rr_ptr_q;
        for (int k = 0; k < CH_NUM; k++) begin
            if (!gnt_vld && !empty[cand]) begin
                gnt_vld = 1'b1;
                gnt_id  = cand;
            end
            cand = ch_inc(cand);
        end
        rr_ptr_d = gnt_vld ? ch_inc(gnt_id) : rr_ptr_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) rr_ptr_q <= '0;
        else         rr_ptr_q <= rr_ptr_d;
    end
`else
    // Scan from the lowest-priority channel so the lowest index wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            if (!empty[k]) begin
                gnt_vld = 1'b1;
                gnt_id  = ch_id_t'(k);
            end
        end
    end
`endif

    always_comb begin
        pop   = '0;
        rsp_d = '0;
        if (gnt_vld) begin
            pop[gnt_id] = 1'b1;
            rsp_d.vld   = 1'b1;
            rsp_d.id    = gnt_id;
            rsp_d.data  = head[gnt_id];
        end
    end

    // Idle cycles register all-zero so data and id read 0 whenever valid is low.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) rsp_q <= '0;
        else         rsp_q <= rsp_d;
    end

    assign mcdt_val_o  = rsp_q.vld;
    assign mcdt_id_o   = rsp_q.id;
    assign mcdt_data_o = rsp_q.data;

endmodule

// File: tb/tb_mcdt_top.sv
// Scoreboard bench for mcdt_top: driver models FIFO occupancy and arbitration, monitor checks the output stream.
`timescale 1ns/1ps
module tb_mcdt_top;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] d [3];
    logic        v [3];
    logic        r [3];
    logic [5:0]  m [3];
    logic [31:0] mcdt_data_o;
    logic        mcdt_val_o;
    logic [1:0]  mcdt_id_o;

    exp_t        sb_q [$];
    logic [31:0] src_q [3][$];
    logic [31:0] mdl_q [3][$];
    bit          will_acc [3];
    bit          gap_ph [3];
    bit          gap_en;
    bit          seen_full;
    int          rr_ptr;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    mcdt_top dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .ch0_data_i   (d[0]),
        .ch0_valid_i  (v[0]),
        .ch0_ready_o  (r[0]),
        .ch0_margin_o (m[0]),
        .ch1_data_i   (d[1]),
        .ch1_valid_i  (v[1]),
        .ch1_ready_o  (r[1]),
        .ch1_margin_o (m[1]),
        .ch2_data_i   (d[2]),
        .ch2_valid_i  (v[2]),
        .ch2_ready_o  (r[2]),
        .ch2_margin_o (m[2]),
        .mcdt_data_o  (mcdt_data_o),
        .mcdt_val_o   (mcdt_val_o),
        .mcdt_id_o    (mcdt_id_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_val"}, mcdt_val_o, 0);
        chk({tag, "_id"}, mcdt_id_o, 0);
        chk({tag, "_data"}, mcdt_data_o, 0);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("%s_ready%0d", tag, c), r[c], 1);
            chk($sformatf("%s_margin%0d", tag, c), m[c], 32);
        end
    endtask

    // Driver: 1ns after each edge, retire the modelled pop/accepts of that edge, then drive the next cycle.
    always begin
        @(posedge clk);
        #1;
        if (!rstn) begin
            for (int c = 0; c < 3; c++) begin
                v[c] = 1'b0;
                will_acc[c] = 1'b0;
            end
        end else begin
            int   g;
            exp_t e;
            g = -1;
            for (int k = 0; k < 3; k++) begin
                int c;
`ifdef MCDT_RR_ARB_EN
                c = (rr_ptr + k) % 3;
`else
                c = k;
`endif
                if (g < 0 && mdl_q[c].size() > 0) g = c;
            end
            if (g >= 0) begin
                e.id   = 2'(g);
                e.data = mdl_q[g].pop_front();
                sb_q.push_back(e);
                rr_ptr = (g + 1) % 3;
            end
            for (int c = 0; c < 3; c++)
                if (will_acc[c]) mdl_q[c].push_back(src_q[c].pop_front());
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("ready%0d", c), r[c], (mdl_q[c].size() < 32) ? 1 : 0);
                chk($sformatf("margin%0d", c), m[c], 32 - mdl_q[c].size());
            end
            for (int c = 0; c < 3; c++) begin
                if (src_q[c].size() > 0 && !(gap_en && gap_ph[c])) begin
                    v[c] = 1'b1;
                    d[c] = src_q[c][0];
                end else begin
                    v[c] = 1'b0;
                    d[c] = $urandom;
                end
                if (gap_en) gap_ph[c] = !gap_ph[c];
                will_acc[c] = v[c] && (mdl_q[c].size() < 32);
                if (c == 1 && v[c] && mdl_q[c].size() == 32) seen_full = 1'b1;
            end
        end
    end

    // Monitor: every output word must match the oldest expected word, in order.
    always @(negedge clk) begin
        if (!rstn) begin
            chk("rst_val", mcdt_val_o, 0);
        end else if (mcdt_val_o) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_out: got id %0d data %0h expected no output at %0t",
                         mcdt_id_o, mcdt_data_o, $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("out_id", mcdt_id_o, e.id);
                chk("out_data", mcdt_data_o, e.data);
            end
        end else begin
            chk("idle_id", mcdt_id_o, 0);
            chk("idle_data", mcdt_data_o, 0);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missing_out: got no valid expected id %0d data %0h at %0t",
                         e.id, e.data, $time);
            end
        end
    end

    function automatic int pending();
        int n;
        n = sb_q.size();
        for (int c = 0; c < 3; c++) n += src_q[c].size() + mdl_q[c].size();
        return n;
    endfunction

    task automatic wait_drain(input string nm);
        int cyc;
        cyc = 0;
        while (pending() != 0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        if (pending() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d words pending expected 0", nm, pending());
        end
        repeat (2) @(negedge clk);
        for (int c = 0; c < 3; c++)
            chk($sformatf("%s_drain_margin%0d", nm, c), m[c], 32);
    endtask

    initial begin
        for (int c = 0; c < 3; c++) begin
            v[c] = 1'b0;
            d[c] = 32'h0;
            gap_ph[c] = 1'b0;
        end
        gap_en = 1'b0;
        seen_full = 1'b0;
        rr_ptr = 0;
        rstn = 1'b0;
        repeat (10) @(negedge clk);
        chk_reset_outputs("reset");
        rstn = 1'b1;

        @(negedge clk);
        for (int n = 0; n < 100; n++) src_q[0].push_back(32'h00C0_0000 + 32'(n));
        wait_drain("single");

        for (int n = 0; n < 100; n++)
            for (int c = 0; c < 3; c++)
                src_q[c].push_back(32'h00C0_0000 + (32'(c) << 16) + 32'(n));
        wait_drain("three_ch");

        // ch0 keeps the arbiter busy long enough for ch1 to fill and stall.
        seen_full = 1'b0;
        for (int n = 0; n < 200; n++) src_q[0].push_back(32'hB000_0000 + 32'(n));
        for (int n = 0; n < 100; n++) src_q[1].push_back(32'hB100_0000 + 32'(n));
        wait_drain("backpressure");
        chk("bp_full_reached", seen_full, 1);

        gap_en = 1'b1;
        for (int n = 0; n < 10; n++) src_q[0].push_back(32'h6A00_0000 + 32'(n));
        for (int n = 0; n < 20; n++) src_q[2].push_back(32'h6C00_0000 + 32'(n));
        wait_drain("gaps");
        gap_en = 1'b0;

        for (int n = 0; n < 50; n++)
            for (int c = 0; c < 3; c++)
                src_q[c].push_back(32'hA000_0000 + (32'(c) << 16) + 32'(n));
        repeat (20) @(negedge clk);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            src_q[c].delete();
            mdl_q[c].delete();
            will_acc[c] = 1'b0;
        end
        sb_q.delete();
        rr_ptr = 0;
        #1;
        chk_reset_outputs("async_rst");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 5; n++) src_q[1].push_back(32'h5EED_0000 + 32'(n));
        for (int n = 0; n < 5; n++) src_q[2].push_back(32'h5EEE_0000 + 32'(n));
        wait_drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
